// File: rtl/shot_pkg.sv
// Shared types and helpers for the shot resolver: FSM state encoding, magazine depth, HP width.
package shot_pkg;
  localparam int MAG_DEPTH = 8;
  localparam int HP_W      = 3;
  localparam int CNT_W     = 4;

  typedef enum logic [2:0] {
    S_EMPTY, S_READY, S_FIRE, S_APPLY, S_ANIM, S_OVER
  } state_e;

  function automatic logic [CNT_W-1:0] clamp_cnt(input logic [CNT_W-1:0] c);
    return (c > CNT_W'(MAG_DEPTH)) ? CNT_W'(MAG_DEPTH) : c;
  endfunction

  function automatic logic [HP_W-1:0] hp_sub(input logic [HP_W-1:0] hp, input logic [HP_W-1:0] dmg);
    return (hp > dmg) ? hp - dmg : '0;
  endfunction
endpackage

// File: rtl/shot_resolver_if.sv
// Control/status bundle between the game controller and shot_resolver.
// SAWED_OFF_EN adds the double-damage arm input and its status output.
interface shot_if;
  logic       i_load;
  logic [7:0] i_shells;
  logic [3:0] i_shell_cnt;
  logic       i_trigger;
  logic       i_shoot_select;
  logic       i_new_game;
  logic [2:0] o_hp_p0;
  logic [2:0] o_hp_p1;
  logic       o_turn;
  logic [3:0] o_shell_left;
  logic       o_need_load;
  logic       o_busy;
  logic       o_result_valid;
  logic       o_result_live;
  logic       o_game_over;
  logic       o_winner;
`ifdef SAWED_OFF_EN
  logic       i_double;
  logic       o_double_armed;
`endif

  modport slave (
    input  i_load, i_shells, i_shell_cnt, i_trigger, i_shoot_select, i_new_game,
`ifdef SAWED_OFF_EN
    input  i_double,
    output o_double_armed,
`endif
    output o_hp_p0, o_hp_p1, o_turn, o_shell_left, o_need_load, o_busy,
    output o_result_valid, o_result_live, o_game_over, o_winner
  );

  modport master (
    output i_load, i_shells, i_shell_cnt, i_trigger, i_shoot_select, i_new_game,
`ifdef SAWED_OFF_EN
    output i_double,
    input  o_double_armed,
`endif
    input  o_hp_p0, o_hp_p1, o_turn, o_shell_left, o_need_load, o_busy,
    input  o_result_valid, o_result_live, o_game_over, o_winner
  );
endinterface

// File: rtl/shell_magazine.sv
// Shell shift register: bit 0 is the next shell; load replaces, pop shifts right and decrements.
module shell_magazine
  import shot_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_load,
  input  logic [MAG_DEPTH-1:0] i_shells,
  input  logic [CNT_W-1:0]     i_cnt,
  input  logic                 i_pop,
  input  logic                 i_clear,
  output logic                 o_head,
  output logic [CNT_W-1:0]     o_cnt,
  output logic                 o_empty
);
  logic [MAG_DEPTH-1:0] bits_q;
  logic [CNT_W-1:0]     cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      bits_q <= '0;
      cnt_q  <= '0;
    end else if (i_load) begin
      bits_q <= i_shells;
      cnt_q  <= clamp_cnt(i_cnt);
    end else if (i_pop && cnt_q != '0) begin
      bits_q <= bits_q >> 1;
      cnt_q  <= cnt_q - 1'b1;
    end
  end

  assign o_head  = bits_q[0];
  assign o_cnt   = cnt_q;
  assign o_empty = (cnt_q == '0);
endmodule

// File: rtl/shot_resolver.sv
// Two-player shot resolver: fire/apply/animate FSM over a shell magazine; result pulses 2 cycles after trigger.
// Optional SAWED_OFF_EN: an armed shot deals 2 damage on a live shell.
module shot_resolver
  import shot_pkg::*;
#(
  parameter int HP_MAX      = 4,
  parameter int ANIM_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  shot_if.slave bus
);
  localparam int AW = (ANIM_CYCLES > 1) ? $clog2(ANIM_CYCLES) : 1;
  localparam logic [AW-1:0]   ANIM_LOAD = AW'(ANIM_CYCLES - 1);
  localparam logic [HP_W-1:0] HP_FULL   = HP_W'(HP_MAX);

  state_e          state_q, state_d;
  logic [HP_W-1:0] hp0_q, hp0_d, hp1_q, hp1_d;
  logic            turn_q, turn_d;
  logic            shell_q, shell_d;
  logic            tgt_q, tgt_d;
  logic            live_q, live_d;
  logic            rv_q, rv_d;
  logic [AW-1:0]   anim_q, anim_d;
  logic [HP_W-1:0] dmg;
  logic            victim;

  logic             mag_load, mag_pop, mag_clear, mag_head, mag_empty;
  logic [CNT_W-1:0] mag_cnt;

  // A zero-count load is ignored both when empty and when replacing.
  assign mag_load  = (state_q == S_EMPTY || state_q == S_READY) && bus.i_load && (bus.i_shell_cnt != '0);
  assign mag_pop   = (state_q == S_FIRE);
  assign mag_clear = (state_q == S_OVER) && bus.i_new_game;

  shell_magazine u_mag (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_load   (mag_load),
    .i_shells (bus.i_shells),
    .i_cnt    (bus.i_shell_cnt),
    .i_pop    (mag_pop),
    .i_clear  (mag_clear),
    .o_head   (mag_head),
    .o_cnt    (mag_cnt),
    .o_empty  (mag_empty)
  );

`ifdef SAWED_OFF_EN
  logic dbl_q, dbl_d;

  always_comb begin
    dbl_d = dbl_q;
    if (state_q == S_READY && bus.i_double) dbl_d = 1'b1;
    if (state_q == S_APPLY || mag_clear)    dbl_d = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) dbl_q <= 1'b0;
    else       dbl_q <= dbl_d;
  end

  assign dmg                = dbl_q ? HP_W'(2) : HP_W'(1);
  assign bus.o_double_armed = dbl_q;
`else
  assign dmg = HP_W'(1);
`endif

  // Target 1 = shooter itself, 0 = the other player.
  assign victim = tgt_q ? turn_q : ~turn_q;

  always_comb begin
    state_d = state_q;
    hp0_d   = hp0_q;
    hp1_d   = hp1_q;
    turn_d  = turn_q;
    shell_d = shell_q;
    tgt_d   = tgt_q;
    live_d  = live_q;
    rv_d    = 1'b0;
    anim_d  = anim_q;
    case (state_q)
      S_EMPTY: if (mag_load) state_d = S_READY;
      S_READY: if (!bus.i_load && bus.i_trigger) state_d = S_FIRE;
      S_FIRE: begin
        shell_d = mag_head;
        tgt_d   = bus.i_shoot_select;
        state_d = S_APPLY;
      end
      S_APPLY: begin
        live_d = shell_q;
        rv_d   = 1'b1;
        if (shell_q) begin
          if (victim) hp1_d = hp_sub(hp1_q, dmg);
          else        hp0_d = hp_sub(hp0_q, dmg);
        end
        if (shell_q || !tgt_q) turn_d = ~turn_q;
        anim_d  = ANIM_LOAD;
        state_d = S_ANIM;
      end
      S_ANIM: begin
        if (anim_q == '0) begin
          if (hp0_q == '0 || hp1_q == '0) state_d = S_OVER;
          else if (mag_empty)             state_d = S_EMPTY;
          else                            state_d = S_READY;
        end else begin
          anim_d = anim_q - 1'b1;
        end
      end
      S_OVER: begin
        if (bus.i_new_game) begin
          hp0_d   = HP_FULL;
          hp1_d   = HP_FULL;
          turn_d  = 1'b0;
          live_d  = 1'b0;
          state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_EMPTY;
      hp0_q   <= HP_FULL;
      hp1_q   <= HP_FULL;
      turn_q  <= 1'b0;
      shell_q <= 1'b0;
      tgt_q   <= 1'b0;
      live_q  <= 1'b0;
      rv_q    <= 1'b0;
      anim_q  <= '0;
    end else begin
      state_q <= state_d;
      hp0_q   <= hp0_d;
      hp1_q   <= hp1_d;
      turn_q  <= turn_d;
      shell_q <= shell_d;
      tgt_q   <= tgt_d;
      live_q  <= live_d;
      rv_q    <= rv_d;
      anim_q  <= anim_d;
    end
  end

  assign bus.o_hp_p0        = hp0_q;
  assign bus.o_hp_p1        = hp1_q;
  assign bus.o_turn         = turn_q;
  assign bus.o_shell_left   = mag_cnt;
  assign bus.o_need_load    = (state_q == S_EMPTY);
  assign bus.o_busy         = (state_q == S_FIRE) || (state_q == S_APPLY) || (state_q == S_ANIM);
  assign bus.o_result_valid = rv_q;
  assign bus.o_result_live  = live_q;
  assign bus.o_game_over    = (state_q == S_OVER);
  assign bus.o_winner       = (state_q == S_OVER) && (hp0_q == '0);
endmodule

// File: doc/shot_resolver.md
SHOT_RESOLVER -- requirements
Module: shot_resolver

Interface
REQ-001 SHALL have parameter HP_MAX, default 4, starting and maximum health per player (1..7).
REQ-002 SHALL have parameter ANIM_CYCLES, default 16, number of cycles the result is held before the next trigger is accepted (>=1).
REQ-003 SHALL have ports:
  i_clk  in  1  sole clock, rising edge.
  i_rst  in  1  synchronous, active-high reset.
  i_load  in  1  one-cycle pulse; load magazine.
  i_shells  in  8  shell bitmap, 1 = live; bit 0 fires first.
  i_shell_cnt  in  4  shells in load (1..8).
  i_trigger  in  1  one-cycle fire pulse.
  i_shoot_select  in  1  1 = current player shoots self, 0 = shoots opponent.
  i_new_game  in  1  one-cycle pulse; restart after game over.
  o_hp_p0, o_hp_p1  out  3 each  player health.
  o_turn  out  1  current shooter (0 = P0, 1 = P1).
  o_shell_left  out  4  shells remaining.
  o_need_load  out  1  magazine empty, not game over.
  o_busy  out  1  shot in progress; trigger ignored.
  o_result_valid  out  1  one-cycle pulse per resolved shot.
  o_result_live  out  1  fired shell was live; held until next shot.
  o_game_over  out  1  a player reached 0 HP.
  o_winner  out  1  valid while o_game_over.

Function
REQ-004 SHALL implement states S_EMPTY, S_READY, S_FIRE, S_APPLY, S_ANIM, S_OVER.
REQ-005 S_EMPTY: i_load with i_shell_cnt != 0 SHALL load the magazine and go to S_READY; i_shell_cnt = 0 SHALL be ignored; i_shell_cnt > 8 SHALL clamp to 8.
REQ-006 S_READY: i_load SHALL replace the magazine; i_trigger SHALL go to S_FIRE; if i_load and i_trigger coincide, the load SHALL win and the trigger SHALL be dropped.
REQ-007 S_FIRE SHALL pop bit 0, shift the magazine right, decrement o_shell_left, and latch i_shoot_select as the target.
REQ-008 S_APPLY: live shell SHALL decrement the target's HP by 1, saturating at 0; blank shell SHALL leave HP unchanged.
REQ-009 Turn rule: a blank at self SHALL keep o_turn; every other outcome SHALL toggle o_turn.
REQ-010 o_result_valid SHALL pulse exactly 2 cycles after the edge that samples i_trigger; o_hp_*, o_turn, o_shell_left and o_result_live SHALL already show updated values in that cycle.
REQ-011 S_ANIM SHALL last ANIM_CYCLES cycles, then go to S_OVER if either HP = 0, else S_EMPTY if o_shell_left = 0, else S_READY.
REQ-012 o_busy SHALL be high in S_FIRE, S_APPLY and S_ANIM only; i_trigger and i_load SHALL be ignored while busy.
REQ-013 S_OVER: o_game_over = 1; o_winner = the player with non-zero HP; all inputs except i_new_game SHALL be ignored.
REQ-014 i_new_game in S_OVER SHALL set both HP to HP_MAX, o_turn = 0, empty the magazine, clear o_result_live, and go to S_EMPTY.
REQ-015 o_need_load SHALL be high exactly in S_EMPTY.

Reset
REQ-016 i_rst SHALL force S_EMPTY, HP = HP_MAX for both players, o_turn = 0, empty magazine, o_shell_left = 0, and all other outputs 0, overriding any operation in flight, including mid-S_ANIM.

Configuration
REQ-017 With SAWED_OFF_EN defined, input i_double (1 bit, pulse) SHALL arm double damage in S_READY only; the next live shell SHALL deal 2 damage, saturating at 0; arming SHALL clear after any shot, blank included; output o_double_armed SHALL show the armed state.
REQ-018 Without SAWED_OFF_EN, i_double and o_double_armed SHALL not exist, and damage SHALL always be 1.

Structure
REQ-019 Package shot_pkg SHALL hold the state enum, MAG_DEPTH = 8, and HP width = 3.
REQ-020 Sub-module shell_magazine SHALL hold the 8-bit shift register and count (load, pop, empty flag).

Verification
REQ-021 Load 8'b0000_0101, cnt 3; P0 triggers, select 0 -> result_live = 1, hp_p1 = 3, turn = 1, shell_left = 2, result_valid 2 cycles after trigger.
REQ-022 Next shell is blank; P1 triggers, select 1 -> hp unchanged, turn stays 1; trigger during ANIM is ignored.
REQ-023 Load and trigger in the same cycle in S_READY -> magazine replaced, no shot.
REQ-024 Four live shots at P1 -> hp_p1 = 0, game_over = 1, winner = 0; i_new_game -> both HP = 4, turn = 0, need_load = 1.
REQ-025 i_rst asserted mid-S_ANIM -> all REQ-016 values on the next cycle.
REQ-026 SAWED_OFF_EN build: double armed, then a live shot at hp 1 -> hp = 0 (saturated), armed flag cleared.
